xor_share_arb: RTL and testbench
================================

Name: xor_share_arb

Overview:
- Shares one registered XOR compute unit (f = a ^ b) between N requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Sits between NPC test/trace sources and the shared XOR datapath, so several agents can use one unit without contention.

Parameters:
- N, 4, number of requesters (2..8)
- W, 32, operand/result width in bits
- IDW, 2, requester-id width; must equal clog2(N) (minimum 1)
- CW, 16, grant-counter width (used only when XSA_STATS_EN is defined)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (rst==0 resets)
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept; combinational, one-hot or zero
- req_a  in  N*W  operand a; requester i at bits [i*W +: W]
- req_b  in  N*W  operand b; same packing as req_a
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  W  registered a ^ b of the granted request
- rsp_id  out  IDW  index of the requester that produced rsp_data
- grant_cnt  out  N*CW  per-requester accepted-request count (XSA_STATS_EN only)

Behaviour:
- State machine: two states, derived from rsp_valid.
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Accept condition: can_acc = !rsp_valid || rsp_ready. This gives one result per cycle sustained.
- Grant rule: when can_acc and |req_valid, grant the first set req_valid bit searching upward from ptr, wrapping at N-1 to 0.
  - req_ready[g]=1 only for the granted g. All other bits are 0.
  - req_ready never depends on rsp_valid except through can_acc.
- On an accepting edge:
  - rsp_data <= req_a[g] ^ req_b[g]
  - rsp_id <= g
  - rsp_valid <= 1
  - ptr <= (g==N-1) ? 0 : g+1
- FULL with rsp_ready=1 and no req_valid: rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- FULL with rsp_ready=0: rsp_valid, rsp_data and rsp_id are held stable. No grant is issued and all req_ready are 0.
- Latency: request accepted at edge k appears with rsp_valid=1 at the output from edge k until it is consumed.
- ptr changes only on an accepted grant, never on rsp_ready alone.
- A requester dropping req_valid before it is granted is legal. It is not remembered.
- Reset, including mid-operation: all state clears immediately and asynchronously; any in-flight result is discarded.
  - rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0
  - grant_cnt all 0
  - req_ready is 0 while rst==0.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants go 0,1,...,N-1,0,...

Optional Feature:
- Macro: XSA_STATS_EN.
- Defined:
  - grant_cnt[i] increments by 1 on every accepted grant to requester i.
  - The counter saturates at 2^CW-1 and does not wrap.
  - It resets to 0.
- Undefined:
  - grant_cnt port and counters are absent.
  - All other behaviour is identical.

Decomposition:
- Package xsa_pkg holds:
  - default constants XSA_N, XSA_W, XSA_CW
  - localparam function for id width (clog2 with minimum 1)
  - typedef for the two-state response enum {RSP_EMPTY, RSP_FULL}
- Sub-module rr_arbiter(N) provides:
  - inputs: req, ptr, en
  - outputs: gnt one-hot, gnt_idx
  - purely combinational; reusable by other NPC shared resources.
- xor_share_arb owns ptr, the response register and the optional counters.

Test Plan:
- Reset/idle: hold rst=0 3 cycles, release, no req -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0 throughout.
- Single request: req_valid=4'b0100, a2=32'hFFFF0000, b2=32'h0F0F0F0F -> req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_data=32'hF0F00F0F, rsp_id=2.
- Round-robin: req_valid=4'b1111 constant, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
- Backpressure: FULL with rsp_id=1, rsp_ready=0 for 5 cycles while req_valid=4'b1111 -> req_ready=0, rsp_data/rsp_id stable; raise rsp_ready -> grant 2 in the same cycle.
- Async reset mid-operation: assert rst=0 between edges while FULL -> rsp_valid falls before the next edge; after release, first grant with req_valid=4'b1010 goes to requester 1 (ptr=0).
- Stats (XSA_STATS_EN, CW=2): requester 3 alone granted 5 times -> grant_cnt[3] reads 1,2,3,3,3; other counters stay 0.

Source files
------------

// File: rtl/xsa_pkg.sv
// Shared constants, id-width helper and response-state type for the XOR share arbiter.
package xsa_pkg;

  localparam int XSA_N  = 4;
  localparam int XSA_W  = 32;
  localparam int XSA_CW = 16;

  function automatic int xsa_id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above ptr, wrapping to 0.
module rr_arbiter
  import xsa_pkg::*;
#(
  parameter int N   = XSA_N,
  parameter int IDW = xsa_id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic [IDW:0]   sum_s;
  logic [IDW-1:0] idx_s;
  logic           found_s;

  // Scan N positions starting at ptr; the first requester hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr} + (IDW+1)'(i);
      sum_s = (sum_s >= (IDW+1)'(N)) ? (sum_s - (IDW+1)'(N)) : sum_s;
      idx_s = sum_s[IDW-1:0];
      if (en && !found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/xor_share_arb.sv
// One registered XOR unit (a ^ b) shared round-robin among N valid/ready requesters.
// Optional per-requester saturating grant counters are built when XSA_STATS_EN is defined.
module xor_share_arb
  import xsa_pkg::*;
#(
  parameter int N   = XSA_N,
  parameter int W   = XSA_W,
  parameter int IDW = xsa_id_width(N),
  parameter int CW  = XSA_CW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic [IDW-1:0] rsp_id
`ifdef XSA_STATS_EN
 ,output logic [N*CW-1:0] grant_cnt
`endif
);

  rsp_state_e     state_r, state_s;
  logic [IDW-1:0] ptr_r;
  logic [W-1:0]   data_r;
  logic [IDW-1:0] id_r;
  logic           can_acc_s;
  logic           acc_s;
  logic [N-1:0]   gnt_s;
  logic [IDW-1:0] gnt_idx_s;

  // Gating with rst keeps every req_ready low while reset is held.
  assign can_acc_s = (state_r == RSP_EMPTY) || rsp_ready;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_r),
    .en      (can_acc_s && rst),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign acc_s     = |gnt_s;
  assign req_ready = gnt_s;
  assign rsp_valid = (state_r == RSP_FULL);
  assign rsp_data  = data_r;
  assign rsp_id    = id_r;

  // Response occupancy next-state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RSP_EMPTY: begin
        if (acc_s) state_s = RSP_FULL;
        else       state_s = RSP_EMPTY;
      end
      RSP_FULL: begin
        if (acc_s)          state_s = RSP_FULL;
        else if (rsp_ready) state_s = RSP_EMPTY;
        else                state_s = RSP_FULL;
      end
      default: state_s = RSP_EMPTY;
    endcase
  end

  // Response occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RSP_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Result capture and pointer advance on each accepted grant; data/id hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= '0;
      id_r   <= '0;
      ptr_r  <= '0;
    end else if (acc_s) begin
      data_r <= req_a[gnt_idx_s*W +: W] ^ req_b[gnt_idx_s*W +: W];
      id_r   <= gnt_idx_s;
      ptr_r  <= (gnt_idx_s == IDW'(N-1)) ? '0 : (gnt_idx_s + IDW'(1));
    end else begin
      data_r <= data_r;
      id_r   <= id_r;
      ptr_r  <= ptr_r;
    end
  end

`ifdef XSA_STATS_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_cnt
    logic [CW-1:0] cnt_r;

    // Saturating count of grants to this requester.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_r <= '0;
      end else if (gnt_s[gi] && (cnt_r != {CW{1'b1}})) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign grant_cnt[gi*CW +: CW] = cnt_r;
  end
`endif

endmodule

// File: tb/tb_xor_share_arb.sv
// Directed self-checking bench for xor_share_arb (N=4, W=32, CW=2); stats steps run when XSA_STATS_EN is defined.
module tb_xor_share_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
`ifdef XSA_STATS_EN
  logic [7:0]   grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data [4];
  logic [1:0]  exp_cnt  [5];

  xor_share_arb #(.N(4), .W(32), .IDW(2), .CW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef XSA_STATS_EN
   ,.grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    req_a     = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_b     = {32'hFF000000, 32'h00FF0000, 32'h0000FF00, 32'h000000FF};
    exp_data[0] = 32'h111111EE;
    exp_data[1] = 32'h2222DD22;
    exp_data[2] = 32'h33CC3333;
    exp_data[3] = 32'hBB444444;
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;

    // reset held 3 cycles; requests asserted in the last one must not be granted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_data",  64'(rsp_data),  64'd0);
      chk("rst_id",    64'(rsp_id),    64'd0);
      if (i == 2) req_valid = 4'b1111;
      else        req_valid = 4'b0000;
      #1;
      chk("rst_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 4'b0000;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_valid", 64'(rsp_valid), 64'd0);
      chk("idle_ready", 64'(req_ready), 64'd0);
    end

    // single request from requester 2
    req_a[64 +: 32] = 32'hFFFF0000;
    req_b[64 +: 32] = 32'h0F0F0F0F;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", 64'(req_ready), 64'h4);
    tick();
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_data",  64'(rsp_data),  64'hF0F00F0F);
    chk("single_id",    64'(rsp_id),    64'd2);
    req_valid = 4'b0000;
    req_a[64 +: 32] = 32'h33333333;
    req_b[64 +: 32] = 32'h00FF0000;
    tick();
    chk("drain_valid", 64'(rsp_valid), 64'd0);
    chk("drain_data",  64'(rsp_data),  64'hF0F00F0F);
    chk("drain_id",    64'(rsp_id),    64'd2);

    // requester 3 alone: pointer wraps back to 0
    req_valid = 4'b1000;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'h8);
    tick();
    chk("wrap_id",   64'(rsp_id),   64'd3);
    chk("wrap_data", 64'(rsp_data), 64'hBB444444);

    // all valid, 10 back-to-back grants: 0,1,2,3,0,1,2,3,0,1
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (i % 4)));
      tick();
      chk("rr_valid", 64'(rsp_valid), 64'd1);
      chk("rr_id",    64'(rsp_id),    64'(i % 4));
      chk("rr_data",  64'(rsp_data),  64'(exp_data[i % 4]));
    end

    // backpressure with id 1 held
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      tick();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id",    64'(rsp_id),    64'd1);
      chk("bp_data",  64'(rsp_data),  64'h2222DD22);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'h4);
    tick();
    chk("bp_release_id", 64'(rsp_id), 64'd2);

    // async reset between edges while FULL (ptr is 3 here)
    rsp_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_data",  64'(rsp_data),  64'd0);
    chk("arst_id",    64'(rsp_id),    64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b1;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    chk("arst_first_ready", 64'(req_ready), 64'h2);
    tick();
    chk("arst_first_id",    64'(rsp_id),   64'd1);
    chk("arst_first_data",  64'(rsp_data), 64'h2222DD22);

`ifdef XSA_STATS_EN
    // requester 3 alone, 5 grants with a 2-bit saturating counter
    rst = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("stat_rst", 64'(grant_cnt), 64'd0);
    tick();
    rst = 1'b1;
    req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stat_cnt3",   64'(grant_cnt[7:6]), 64'(exp_cnt[i]));
      chk("stat_others", 64'(grant_cnt[5:0]), 64'd0);
    end
    req_valid = 4'b0000;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
